// File: rtl/line_arbiter_if.sv
// line_arbiter_if: bundles the split I/D cache-line request paths and the
// single burst main-memory port around the line arbiter.
//   slave  : arbiter view (takes line requests and memory beats, drives
//            line responses and the burst command/write beats)
//   master : environment view (caches + memory model), the mirror image
interface line_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
);
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [BEAT_W-1:0] pmem_wdata;
    logic [BEAT_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata,
               pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
               pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata,
               pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
               pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/line_arbiter.sv
// line_arbiter: arbitrates instruction-line reads against data-line
// reads/writes and turns each granted 256-bit line into a BEATS-beat burst
// on the physical memory port, then pulses a one-cycle response carrying
// the assembled line back to the granted side.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - line_arbiter_if.slave: i_* / d_* line requests and responses,
//          pmem_* burst port (read/write held for the whole burst,
//          one pmem_resp per beat)
// Interface parameters must match ADDR_W/LINE_W/BEAT_W here.
module line_arbiter #(
    parameter int BEATS  = 4,
    parameter int BEAT_W = 64,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    line_arbiter_if.slave bus
);
    localparam int K_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFF_W;
    localparam logic [K_W-1:0]    LAST_K     = K_W'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} state_t;

    state_t                       state, state_nxt;
    logic [K_W-1:0]               k;
    logic [BEATS-1:0][BEAT_W-1:0] line_buf;
    logic [BEATS-1:0][BEAT_W-1:0] wline;
    logic [ADDR_W-1:0]            addr_q;
    logic                         last_d;   // last grant went to D (reset: I)
    logic                         want_i, want_d, grant, grant_d, in_burst;

    assign want_i   = bus.i_read;
    assign want_d   = bus.d_read | bus.d_write;
    assign grant    = (state == IDLE) && (want_i || want_d);
    // On contention D wins unless it won last time, so neither side waits
    // more than one transaction.
    assign grant_d  = want_d && (!want_i || !last_d);
    assign in_burst = (state == I_RD) || (state == D_RD) || (state == D_WR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.i_resp       = 1'b0;
        bus.d_resp       = 1'b0;
        bus.i_rdata      = '0;
        bus.d_rdata      = '0;
        bus.pmem_address = addr_q;
        bus.pmem_wdata   = wline[k];
        case (state)
            IDLE: begin
                if (grant) begin
                    if (!grant_d)         state_nxt = I_RD;
                    else if (bus.d_write) state_nxt = D_WR;   // write wins over an illegal read+write
                    else                  state_nxt = D_RD;
                end
            end
            I_RD, D_RD: begin
                bus.pmem_read = 1'b1;
                if (bus.pmem_resp && k == LAST_K) state_nxt = DONE;
            end
            D_WR: begin
                bus.pmem_write = 1'b1;
                if (bus.pmem_resp && k == LAST_K) state_nxt = DONE;
            end
            DONE: begin
                // last_d was updated at grant time, so it names the owner
                // of the transaction completing now.
                if (last_d) begin
                    bus.d_resp  = 1'b1;
                    bus.d_rdata = line_buf;
                end else begin
                    bus.i_resp  = 1'b1;
                    bus.i_rdata = line_buf;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k        <= '0;
            line_buf <= '0;
            wline    <= '0;
            addr_q   <= '0;
            last_d   <= 1'b0;
        end else if (grant) begin
            addr_q <= (grant_d ? bus.d_address : bus.i_address) & ALIGN_MASK;
            last_d <= grant_d;
            k      <= '0;
            if (grant_d && bus.d_write) wline <= bus.d_wdata;
        end else if (in_burst && bus.pmem_resp) begin
            if (state != D_WR) line_buf[k] <= bus.pmem_rdata;
            k <= (k == LAST_K) ? '0 : k + K_W'(1);
        end
    end
endmodule

// File: tb/tb_line_arbiter.sv
module tb_line_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    line_arbiter_if #(.ADDR_W(32), .LINE_W(256), .BEAT_W(64)) bus ();

    line_arbiter #(.BEATS(4), .BEAT_W(64), .LINE_W(256), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           rd_cyc;
        int           wr_cyc;
        int           first_act;
        int           resp_cyc;
        bit           got_i;
        bit           got_d;
        bit           both_hi;
        bit           addr_moved;
        bit           timeout;
        logic [31:0]  addr;
        logic [255:0] rdata;
        logic [255:0] wseen;
    } obs_t;

    // Memory model: answers an active burst with one beat every gap+1
    // cycles, records write beats, and returns at the first resp cycle
    // (still inside that cycle). Called #1 after a rising edge.
    task automatic mem_burst(input int gap, input logic [255:0] rline, output obs_t o);
        int w;
        int b;
        o.rd_cyc = 0; o.wr_cyc = 0; o.first_act = -1; o.resp_cyc = -1;
        o.got_i = 0; o.got_d = 0; o.both_hi = 0; o.addr_moved = 0; o.timeout = 0;
        o.addr = '0; o.rdata = '0; o.wseen = '0;
        w = 0;
        b = 0;
        for (int n = 0; n < 200; n++) begin
            if (bus.i_resp || bus.d_resp) begin
                o.got_i    = bus.i_resp;
                o.got_d    = bus.d_resp;
                o.rdata    = bus.i_resp ? bus.i_rdata : bus.d_rdata;
                o.resp_cyc = n;
                bus.pmem_resp = 1'b0;
                return;
            end
            if (bus.pmem_read && bus.pmem_write) o.both_hi = 1;
            if (bus.pmem_read || bus.pmem_write) begin
                if (o.first_act < 0) begin
                    o.first_act = n;
                    o.addr      = bus.pmem_address;
                end else if (bus.pmem_address !== o.addr) begin
                    o.addr_moved = 1;
                end
                if (bus.pmem_read)  o.rd_cyc++;
                if (bus.pmem_write) o.wr_cyc++;
                if (w == gap && b < 4) begin
                    bus.pmem_resp  = 1'b1;
                    bus.pmem_rdata = rline[b*64 +: 64];
                    o.wseen[b*64 +: 64] = bus.pmem_wdata;
                    b++;
                    w = 0;
                end else begin
                    bus.pmem_resp = 1'b0;
                    w++;
                end
            end else begin
                bus.pmem_resp = 1'b0;
            end
            @(posedge clk); #1;
        end
        o.timeout     = 1;
        bus.pmem_resp = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.i_read = 0; bus.i_address = '0;
        bus.d_read = 0; bus.d_write = 0; bus.d_address = '0; bus.d_wdata = '0;
        bus.pmem_resp = 0; bus.pmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000",
                     {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp});
        end
        checks++;
        if (bus.pmem_address !== 32'h0) begin
            errors++;
            $display("FAIL reset_addr: got %h expected 0", bus.pmem_address);
        end
        checks++;
        if (bus.pmem_wdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_wdata: got %h expected 0", bus.pmem_wdata);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_instr_read();
        obs_t o;
        logic [255:0] l1;
        l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        bus.i_read = 1; bus.i_address = 32'h0000_0064;
        mem_burst(0, l1, o);
        bus.i_read = 0;
        checks++;
        if (o.timeout || !o.got_i || o.got_d) begin
            errors++;
            $display("FAIL ird_resp: got i=%0b d=%0b timeout=%0b expected i=1 d=0", o.got_i, o.got_d, o.timeout);
        end
        checks++;
        if (o.addr !== 32'h0000_0060 || o.addr_moved) begin
            errors++;
            $display("FAIL ird_addr: got %h moved=%0b expected 00000060", o.addr, o.addr_moved);
        end
        checks++;
        if (o.rd_cyc != 4 || o.wr_cyc != 0) begin
            errors++;
            $display("FAIL ird_cycles: got rd=%0d wr=%0d expected rd=4 wr=0", o.rd_cyc, o.wr_cyc);
        end
        checks++;
        if (o.first_act != 1 || o.resp_cyc != 5) begin
            errors++;
            $display("FAIL ird_latency: got first=%0d resp=%0d expected 1 and 5", o.first_act, o.resp_cyc);
        end
        checks++;
        if (o.rdata !== l1) begin
            errors++;
            $display("FAIL ird_rdata: got %h expected %h", o.rdata, l1);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin
            errors++;
            $display("FAIL ird_pulse: got i=%b d=%b expected 0 0 after one cycle", bus.i_resp, bus.d_resp);
        end
    endtask

    task automatic test_data_write();
        obs_t o;
        logic [255:0] wl;
        wl = {64'hD3D3_D3D3_0000_0003, 64'hD2D2_D2D2_0000_0002,
              64'hD1D1_D1D1_0000_0001, 64'hD0D0_D0D0_0000_0000};
        bus.d_write = 1; bus.d_address = 32'h8000_0020; bus.d_wdata = wl;
        mem_burst(0, 256'h0, o);
        bus.d_write = 0;
        bus.d_wdata = '1;
        checks++;
        if (o.timeout || !o.got_d || o.got_i) begin
            errors++;
            $display("FAIL dwr_resp: got i=%0b d=%0b timeout=%0b expected i=0 d=1", o.got_i, o.got_d, o.timeout);
        end
        checks++;
        if (o.addr !== 32'h8000_0020) begin
            errors++;
            $display("FAIL dwr_addr: got %h expected 80000020", o.addr);
        end
        checks++;
        if (o.wr_cyc != 4 || o.rd_cyc != 0 || o.both_hi) begin
            errors++;
            $display("FAIL dwr_cycles: got wr=%0d rd=%0d both=%0b expected 4 0 0", o.wr_cyc, o.rd_cyc, o.both_hi);
        end
        checks++;
        if (o.wseen !== wl) begin
            errors++;
            $display("FAIL dwr_beats: got %h expected %h", o.wseen, wl);
        end
        checks++;
        if (o.resp_cyc != o.first_act + 4) begin
            errors++;
            $display("FAIL dwr_latency: got resp=%0d expected %0d", o.resp_cyc, o.first_act + 4);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_arbitration();
        obs_t o;
        logic [255:0] la, lb, lc;
        la = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002, 64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
        lb = {64'hB3B3_1111_2222_3333, 64'hB2B2_1111_2222_3333, 64'hB1B1_1111_2222_3333, 64'hB0B0_1111_2222_3333};
        lc = {64'hC3C3_C3C3_5555_AAAA, 64'hC2C2_C2C2_5555_AAAA, 64'hC1C1_C1C1_5555_AAAA, 64'hC0C0_C0C0_5555_AAAA};
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        bus.d_read = 1; bus.d_address = 32'h0000_1234;
        bus.i_read = 1; bus.i_address = 32'h0000_4047;
        mem_burst(2, la, o);
        // New data request raised while DONE; I is still pending.
        bus.d_address = 32'h0000_2FFF;
        checks++;
        if (o.timeout || !o.got_d || o.got_i || o.addr !== 32'h0000_1220) begin
            errors++;
            $display("FAIL arb_first_d: got d=%0b i=%0b addr=%h expected d=1 i=0 addr=00001220", o.got_d, o.got_i, o.addr);
        end
        checks++;
        if (o.rd_cyc != 12 || o.rdata !== la) begin
            errors++;
            $display("FAIL arb_d_data: got rd=%0d data=%h expected 12 %h", o.rd_cyc, o.rdata, la);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.d_resp !== 1'b0) begin
            errors++;
            $display("FAIL arb_d_pulse: got %b expected 0", bus.d_resp);
        end
        mem_burst(2, lb, o);
        bus.i_read = 0;
        checks++;
        if (o.timeout || !o.got_i || o.got_d || o.addr !== 32'h0000_4040) begin
            errors++;
            $display("FAIL arb_alt_i: got i=%0b d=%0b addr=%h expected i=1 d=0 addr=00004040", o.got_i, o.got_d, o.addr);
        end
        checks++;
        if (o.rdata !== lb) begin
            errors++;
            $display("FAIL arb_i_data: got %h expected %h", o.rdata, lb);
        end
        @(posedge clk); #1;
        mem_burst(2, lc, o);
        bus.d_read = 0;
        checks++;
        if (o.timeout || !o.got_d || o.addr !== 32'h0000_2FE0 || o.rdata !== lc) begin
            errors++;
            $display("FAIL arb_third_d: got d=%0b addr=%h data=%h expected 1 00002fe0 %h", o.got_d, o.addr, o.rdata, lc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_burst();
        obs_t o;
        logic [255:0] l4;
        l4 = {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001};
        bus.i_read = 1; bus.i_address = 32'h0000_0100;
        @(posedge clk); #1;
        checks++;
        if (bus.pmem_read !== 1'b1) begin
            errors++;
            $display("FAIL rmb_start: got pmem_read=%b expected 1", bus.pmem_read);
        end
        bus.pmem_resp = 1; bus.pmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        @(posedge clk); #1;
        bus.pmem_rdata = 64'hBAD1_BAD1_BAD1_BAD1;
        @(posedge clk); #1;
        bus.pmem_resp = 0;
        bus.i_read = 0;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.pmem_read !== 1'b0 || bus.pmem_address !== 32'h0) begin
            errors++;
            $display("FAIL rmb_async: got read=%b addr=%h expected 0 0", bus.pmem_read, bus.pmem_address);
        end
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus.i_resp, bus.d_resp, bus.pmem_read, bus.pmem_write} !== 4'b0) begin
                errors++;
                $display("FAIL rmb_hold: got %b expected 0000",
                         {bus.i_resp, bus.d_resp, bus.pmem_read, bus.pmem_write});
            end
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        bus.i_read = 1; bus.i_address = 32'h0000_0300;
        mem_burst(0, l4, o);
        bus.i_read = 0;
        checks++;
        if (o.timeout || !o.got_i || o.rd_cyc != 4 || o.addr !== 32'h0000_0300) begin
            errors++;
            $display("FAIL rmb_after: got i=%0b rd=%0d addr=%h expected 1 4 00000300", o.got_i, o.rd_cyc, o.addr);
        end
        checks++;
        if (o.rdata !== l4) begin
            errors++;
            $display("FAIL rmb_rdata: got %h expected %h", o.rdata, l4);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal_rw();
        obs_t o;
        logic [255:0] w5;
        w5 = {64'h5555_0003_0003_0003, 64'h5555_0002_0002_0002, 64'h5555_0001_0001_0001, 64'h5555_0000_0000_0000};
        bus.d_read = 1; bus.d_write = 1; bus.d_address = 32'h0000_0555; bus.d_wdata = w5;
        mem_burst(0, 256'h0, o);
        bus.d_read = 0; bus.d_write = 0;
        checks++;
        if (o.timeout || !o.got_d || o.wr_cyc != 4 || o.rd_cyc != 0 || o.both_hi) begin
            errors++;
            $display("FAIL rw_kind: got d=%0b wr=%0d rd=%0d both=%0b expected 1 4 0 0", o.got_d, o.wr_cyc, o.rd_cyc, o.both_hi);
        end
        checks++;
        if (o.wseen !== w5 || o.addr !== 32'h0000_0540) begin
            errors++;
            $display("FAIL rw_data: got addr=%h beats=%h expected 00000540 %h", o.addr, o.wseen, w5);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_spurious_resp();
        obs_t o;
        logic [255:0] l6;
        l6 = {64'h6666_0000_0000_0044, 64'h6666_0000_0000_0033, 64'h6666_0000_0000_0022, 64'h6666_0000_0000_0011};
        for (int n = 0; n < 3; n++) begin
            bus.pmem_resp = 1; bus.pmem_rdata = 64'hDEAD_BEEF_0000_0000 | 64'(n);
            @(posedge clk); #1;
            checks++;
            if ({bus.i_resp, bus.d_resp, bus.pmem_read, bus.pmem_write} !== 4'b0) begin
                errors++;
                $display("FAIL spur_idle: got %b expected 0000",
                         {bus.i_resp, bus.d_resp, bus.pmem_read, bus.pmem_write});
            end
        end
        bus.pmem_resp = 0;
        bus.i_read = 1; bus.i_address = 32'h0000_0777;
        mem_burst(0, l6, o);
        bus.i_read = 0;
        checks++;
        if (o.timeout || !o.got_i || o.rd_cyc != 4 || o.addr !== 32'h0000_0760 || o.rdata !== l6) begin
            errors++;
            $display("FAIL spur_after: got i=%0b rd=%0d addr=%h data=%h expected 1 4 00000760 %h",
                     o.got_i, o.rd_cyc, o.addr, o.rdata, l6);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_instr_read();
        test_data_write();
        test_arbitration();
        test_reset_mid_burst();
        test_illegal_rw();
        test_spurious_resp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/line_arbiter.md
Name: line_arbiter

Overview:
- Sits directly downstream of the CPU's instruction and data cache-line paths, between the split I/D line requests and the single burst main-memory port.
- Arbitrates between instruction-line reads and data-line reads and writes.
- Converts each granted 256-bit line transfer into a fixed 4-beat, 64-bit burst on physical memory.
- Returns the assembled line with a one-cycle response to the granted requester.

Parameters:
BEATS, 4, beats per line burst
BEAT_W, 64, physical memory data width in bits
LINE_W, 256, line width in bits; must equal BEATS*BEAT_W
ADDR_W, 32, address width in bits

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
i_read  in  1  instruction-line read request, held until i_resp
i_address  in  ADDR_W  instruction-line address
i_rdata  out  LINE_W  instruction line, valid only while i_resp=1
i_resp  out  1  one-cycle completion pulse for the instruction request
d_read  in  1  data-line read request, held until d_resp
d_write  in  1  data-line write request, held until d_resp
d_address  in  ADDR_W  data-line address
d_wdata  in  LINE_W  data line to write
d_rdata  out  LINE_W  data line, valid only while d_resp=1
d_resp  out  1  one-cycle completion pulse for the data request
pmem_read  out  1  burst read to physical memory
pmem_write  out  1  burst write to physical memory
pmem_address  out  ADDR_W  line-aligned burst address
pmem_wdata  out  BEAT_W  current write beat
pmem_rdata  in  BEAT_W  current read beat, valid when pmem_resp=1
pmem_resp  in  1  one pulse per completed beat

Behaviour:
- Reset:
  - FSM enters IDLE immediately when rst=0, including mid-burst.
  - All outputs are 0 during reset: pmem_read, pmem_write, i_resp, d_resp, pmem_address, pmem_wdata.
  - Beat counter, line buffer, latched address and last_grant (=I) are cleared.
- FSM states: IDLE, I_RD, D_RD, D_WR, DONE.
- IDLE arbitration, sampled each cycle:
  - Data request only -> grant D.
  - Instruction request only -> grant I.
  - Both pending -> grant D unless last_grant=D, in which case grant I. This alternation bounds starvation to one transaction.
  - d_read and d_write both high is illegal; d_write takes precedence.
- On grant:
  - Latch the address with bits [4:0] forced to 0, and latch d_wdata for writes.
  - Update last_grant.
  - Next state is I_RD, D_RD or D_WR.
- Burst states:
  - pmem_read (I_RD, D_RD) or pmem_write (D_WR) is decoded from state and held continuously for all BEATS beats.
  - pmem_address holds the latched aligned address for the whole burst.
  - beat counter k runs 0..BEATS-1 and advances on each pmem_resp.
  - Read: on pmem_resp, pmem_rdata is written into buffer bits [BEAT_W*k+BEAT_W-1 : BEAT_W*k].
  - Write: pmem_wdata = latched line bits [BEAT_W*k+BEAT_W-1 : BEAT_W*k], combinational from k.
  - pmem_resp on beat BEATS-1 -> DONE; pmem_read and pmem_write drop that same edge.
- DONE (exactly one cycle):
  - Assert i_resp or d_resp for the granted requester.
  - i_rdata and d_rdata are driven from the line buffer; undefined outside resp (0 permitted).
  - Requests are ignored; next state is IDLE.
  - The requester drops its request on the following edge, so IDLE never re-grants a completed request.
- Latency: request seen at edge t -> pmem_read high in cycle t+1. With pmem_resp every cycle, resp is high in cycle t+5.
- Dropped request: if the requester drops its request mid-burst, the burst still completes and resp still pulses.
- Address or wdata changes during the transaction are ignored (latched copies are used).
- pmem_resp in IDLE or DONE is ignored.
- Only one burst is outstanding at any time; pmem_read and pmem_write are never both high.

Test Plan:
1. Reset, then single instruction read: i_read, i_address=0x0000_0064; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles. Required: pmem_address=0x0000_0060, pmem_read high for 4 cycles, i_resp high 1 cycle at t+5, i_rdata={0x44..44,0x33..33,0x22..22,0x11..11}, d_resp stays 0.
2. Data write: d_write, d_address=0x8000_0020, d_wdata=256'h(D3)(D2)(D1)(D0) beats. Required: pmem_write high, pmem_wdata sequence D0, D1, D2, D3, d_resp 1 cycle after the 4th pmem_resp.
3. Simultaneous d_read and i_read from reset (last_grant=I): D is served first, then I. A second simultaneous request after the D grant is served as I (alternation). Memory inserts 2 wait cycles between beats; beats must still assemble correctly.
4. Reset mid-burst: assert rst=0 after beat 2 of a read. Required: pmem_read drops asynchronously, no resp pulse. After release, a new i_read completes normally with beat order restarting at 0.
5. Illegal d_read and d_write together: a write burst is issued. Spurious pmem_resp while in IDLE: no counter advance, no resp.
